// File: rtl/rsa_cpu_pkg.sv
// rsa_cpu_pkg
//   Shared definitions for the RSA pipeline CPU: condition-code encodings,
//   NZCV flag bit positions and ALU opcode constants.
package rsa_cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;
  localparam logic [2:0] ALU_MOD = 3'b101;

endpackage

// File: rtl/cond_check.sv
// cond_check
//   Combinational evaluation of a 4-bit condition code against NZCV flags.
//   Ports:
//     cond_i  [3:0]  condition code (cond_e encoding)
//     flags_i [3:0]  {N,Z,C,V}
//     pass_o         1 when the condition holds
module cond_check
  import rsa_cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_commit_stage.sv
// exec_commit_stage
//   Execute-to-memory commit stage. Evaluates the EX instruction's condition
//   against the architectural NZCV register, updates that register, and
//   captures the gated result/control into the EX/MEM pipeline register.
//   Ports:
//     clk_i, rst_ni                     clock, async active-low reset
//     valid_i                           real instruction present in EX
//     result_i, alu_flags_i             ALU result and {N,Z,C,V}
//     wdata_i, rd_i                     store data, destination register
//     cond_i, flag_write_i              condition code, flag-setting enable
//     reg_write_i, mem_write_i,
//     mem_to_reg_i, branch_i            decoded control
//     stall_i, flush_i                  hazard-unit hold / squash
//     valid_o, reg_write_o,
//     mem_write_o, mem_to_reg_o         registered control
//     result_o, wdata_o, rd_o           registered data
//     flags_o                           architectural NZCV
//     cond_pass_o, branch_taken_o       same-cycle condition / branch result
//
// Pipeline control: flush_i has priority and loads a bubble (all zero);
// otherwise stall_i holds the EX/MEM register and the flags; otherwise the
// register advances every cycle. There is no backpressure beyond stall_i.
module exec_commit_stage
  import rsa_cpu_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [N-1:0] result_i,
  input  logic [3:0]   alu_flags_i,
  input  logic [N-1:0] wdata_i,
  input  logic [R-1:0] rd_i,
  input  logic [3:0]   cond_i,
  input  logic         flag_write_i,
  input  logic         reg_write_i,
  input  logic         mem_write_i,
  input  logic         mem_to_reg_i,
  input  logic         branch_i,
  input  logic         stall_i,
  input  logic         flush_i,
  output logic         valid_o,
  output logic         reg_write_o,
  output logic         mem_write_o,
  output logic         mem_to_reg_o,
  output logic [N-1:0] result_o,
  output logic [N-1:0] wdata_o,
  output logic [R-1:0] rd_o,
  output logic [3:0]   flags_o,
  output logic         cond_pass_o,
  output logic         branch_taken_o
);

  logic [3:0]   flags_q, flags_d;
  logic         valid_q, valid_d;
  logic         reg_write_q, reg_write_d;
  logic         mem_write_q, mem_write_d;
  logic         mem_to_reg_q, mem_to_reg_d;
  logic [N-1:0] result_q, result_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [R-1:0] rd_q, rd_d;

  logic cond_pass;
  logic exec;

  // Condition is evaluated against the stored flags, so a flag-setting
  // instruction only affects the instruction after it.
  cond_check u_cond_check (
    .cond_i  (cond_i),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  assign exec           = valid_i & cond_pass;
  assign cond_pass_o    = cond_pass;
  assign branch_taken_o = valid_i & branch_i & cond_pass & ~flush_i;

  always_comb begin
    flags_d = flags_q;
    if (exec & flag_write_i & ~stall_i & ~flush_i) begin
      flags_d = alu_flags_i;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    result_d     = result_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      result_d     = '0;
      wdata_d      = '0;
      rd_d         = '0;
    end else if (!stall_i) begin
      // A failed condition still advances as a valid no-op.
      valid_d      = valid_i;
      reg_write_d  = reg_write_i & exec;
      mem_write_d  = mem_write_i & exec;
      mem_to_reg_d = mem_to_reg_i & exec;
      result_d     = result_i;
      wdata_d      = wdata_i;
      rd_d         = rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q      <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      result_q     <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
    end else begin
      flags_q      <= flags_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      result_q     <= result_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
    end
  end

  assign flags_o      = flags_q;
  assign valid_o      = valid_q;
  assign reg_write_o  = reg_write_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign result_o     = result_q;
  assign wdata_o      = wdata_q;
  assign rd_o         = rd_q;

endmodule

// File: tb/tb_exec_commit_stage.sv
// Directed bench for exec_commit_stage. Inputs change 1 time unit after the
// rising edge; registered outputs are sampled 1 time unit after the edge
// that captured them, combinational outputs 1 time unit after driving.
module tb_exec_commit_stage;

  localparam int N = 32;
  localparam int R = 4;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic [N-1:0] result_i;
  logic [3:0]   alu_flags_i;
  logic [N-1:0] wdata_i;
  logic [R-1:0] rd_i;
  logic [3:0]   cond_i;
  logic         flag_write_i;
  logic         reg_write_i;
  logic         mem_write_i;
  logic         mem_to_reg_i;
  logic         branch_i;
  logic         stall_i;
  logic         flush_i;
  logic         valid_o;
  logic         reg_write_o;
  logic         mem_write_o;
  logic         mem_to_reg_o;
  logic [N-1:0] result_o;
  logic [N-1:0] wdata_o;
  logic [R-1:0] rd_o;
  logic [3:0]   flags_o;
  logic         cond_pass_o;
  logic         branch_taken_o;

  int n_checks = 0;
  int n_fail   = 0;

  exec_commit_stage #(.N(N), .R(R)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_i        (valid_i),
    .result_i       (result_i),
    .alu_flags_i    (alu_flags_i),
    .wdata_i        (wdata_i),
    .rd_i           (rd_i),
    .cond_i         (cond_i),
    .flag_write_i   (flag_write_i),
    .reg_write_i    (reg_write_i),
    .mem_write_i    (mem_write_i),
    .mem_to_reg_i   (mem_to_reg_i),
    .branch_i       (branch_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .reg_write_o    (reg_write_o),
    .mem_write_o    (mem_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .result_o       (result_o),
    .wdata_o        (wdata_o),
    .rd_o           (rd_o),
    .flags_o        (flags_o),
    .cond_pass_o    (cond_pass_o),
    .branch_taken_o (branch_taken_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_i      = 1'b0;
    result_i     = '0;
    alu_flags_i  = '0;
    wdata_i      = '0;
    rd_i         = '0;
    cond_i       = 4'b1110;
    flag_write_i = 1'b0;
    reg_write_i  = 1'b0;
    mem_write_i  = 1'b0;
    mem_to_reg_i = 1'b0;
    branch_i     = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] res, input logic [3:0] af,
                       input logic [N-1:0] wd, input logic [R-1:0] rd, input logic [3:0] cond,
                       input logic fw, input logic rw, input logic mw, input logic m2r,
                       input logic br);
    valid_i      = v;
    result_i     = res;
    alu_flags_i  = af;
    wdata_i      = wd;
    rd_i         = rd;
    cond_i       = cond;
    flag_write_i = fw;
    reg_write_i  = rw;
    mem_write_i  = mw;
    mem_to_reg_i = m2r;
    branch_i     = br;
  endtask

  // Load the flag register through a qualified AL flag-setting instruction.
  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, 32'd0, f, 32'd0, 4'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({valid_o, reg_write_o, mem_write_o, mem_to_reg_o, result_o, wdata_o, rd_o, flags_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got result=%h flags=%b valid=%b want all zero", result_o, flags_o, valid_o);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    // Unqualified flag write on the first edge after release must not load.
    drive(1'b0, 32'h1234, 4'b1111, 32'h55, 4'd7, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    n_checks++;
    if (flags_o !== 4'b0000 || reg_write_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_unqualified: got flags=%b rw=%b valid=%b want 0000 0 0", flags_o, reg_write_o, valid_o);
    end
    // Mid-stream: make outputs nonzero, then reset with no clock edge.
    drive(1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hCAFE, 4'd9, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    n_checks++;
    if (result_o !== 32'hDEAD_BEEF || flags_o !== 4'b1111 || mem_write_o !== 1'b1 || rd_o !== 4'd9) begin
      n_fail++;
      $display("FAIL reset_preload: got result=%h flags=%b mw=%b rd=%0d want deadbeef 1111 1 9", result_o, flags_o, mem_write_o, rd_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, reg_write_o, mem_write_o, mem_to_reg_o, result_o, wdata_o, rd_o, flags_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got result=%h wdata=%h flags=%b valid=%b want all zero", result_o, wdata_o, flags_o, valid_o);
    end
    drive_idle();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_cond_eq_ne();
    // SUB 10-10 sets Z.
    drive(1'b1, 32'd0, 4'b0100, 32'd0, 4'd1, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (flags_o !== 4'b0100 || valid_o !== 1'b1 || reg_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_sets_z: got flags=%b valid=%b rw=%b want 0100 1 1", flags_o, valid_o, reg_write_o);
    end
    drive(1'b1, 32'd77, 4'b0000, 32'd0, 4'd2, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (cond_pass_o !== 1'b1) begin
      n_fail++;
      $display("FAIL eq_pass_comb: got %b want 1", cond_pass_o);
    end
    step();
    n_checks++;
    if (reg_write_o !== 1'b1 || result_o !== 32'd77 || rd_o !== 4'd2) begin
      n_fail++;
      $display("FAIL eq_commit: got rw=%b result=%0d rd=%0d want 1 77 2", reg_write_o, result_o, rd_o);
    end
    // NE fails: valid no-op, all writes suppressed.
    drive(1'b1, 32'd88, 4'b0000, 32'd5, 4'd3, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    n_checks++;
    if (valid_o !== 1'b1 || reg_write_o !== 1'b0 || mem_write_o !== 1'b0 || mem_to_reg_o !== 1'b0
        || result_o !== 32'd88 || wdata_o !== 32'd5 || flags_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL ne_noop: got valid=%b rw=%b mw=%b m2r=%b result=%0d wdata=%0d flags=%b want 1 0 0 0 88 5 0100",
               valid_o, reg_write_o, mem_write_o, mem_to_reg_o, result_o, wdata_o, flags_o);
    end
    drive_idle();
  endtask

  task automatic test_signed_compare();
    logic [3:0] conds [9];
    logic       exp   [9];
    conds = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b1000, 4'b1001};
    exp   = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
    set_flags(4'b1000);
    n_checks++;
    if (flags_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL signed_flags_setup: got %b want 1000", flags_o);
    end
    for (int i = 0; i < 9; i++) begin
      cond_i  = conds[i];
      valid_i = 1'b1;
      #1;
      n_checks++;
      if (cond_pass_o !== exp[i]) begin
        n_fail++;
        $display("FAIL signed_cond_%b: got %b want %b", conds[i], cond_pass_o, exp[i]);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_stall();
    // ADD 1+10 = 11, flags currently 1000.
    drive(1'b1, 32'd11, 4'b0000, 32'd100, 4'd3, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (result_o !== 32'd11 || rd_o !== 4'd3 || wdata_o !== 32'd100) begin
      n_fail++;
      $display("FAIL add_result: got result=%0d rd=%0d wdata=%0d want 11 3 100", result_o, rd_o, wdata_o);
    end
    // OR 11|10 = 11, flag-setting, held under stall.
    drive(1'b1, 32'd11, 4'b0000, 32'd200, 4'd5, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (result_o !== 32'd11 || rd_o !== 4'd3 || wdata_o !== 32'd100 || mem_write_o !== 1'b0 || flags_o !== 4'b1000) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got result=%0d rd=%0d wdata=%0d mw=%b flags=%b want 11 3 100 0 1000",
                 c, result_o, rd_o, wdata_o, mem_write_o, flags_o);
      end
    end
    stall_i = 1'b0;
    step();
    n_checks++;
    if (result_o !== 32'd11 || rd_o !== 4'd5 || wdata_o !== 32'd200 || mem_write_o !== 1'b1 || flags_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_release: got result=%0d rd=%0d wdata=%0d mw=%b flags=%b want 11 5 200 1 0000",
               result_o, rd_o, wdata_o, mem_write_o, flags_o);
    end
    // Non-flag-setting follower: flags must stay at the single update.
    drive(1'b1, 32'd4, 4'b1111, 32'd0, 4'd6, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (flags_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_single_update: got flags=%b want 0000", flags_o);
    end
    drive_idle();
  endtask

  task automatic test_flush_stall();
    // Valid MOD, flag-setting, branch, under both flush and stall.
    drive(1'b1, 32'd3, 4'b0110, 32'd9, 4'd8, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    stall_i = 1'b1;
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (branch_taken_o !== 1'b0 || cond_pass_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_branch_comb: got bt=%b cp=%b want 0 1", branch_taken_o, cond_pass_o);
    end
    step();
    n_checks++;
    if ({valid_o, reg_write_o, mem_write_o, mem_to_reg_o, result_o, wdata_o, rd_o} !== '0 || flags_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_bubble: got valid=%b rw=%b result=%0d rd=%0d flags=%b want 0 0 0 0 0000",
               valid_o, reg_write_o, result_o, rd_o, flags_o);
    end
    drive_idle();
  endtask

  task automatic test_branch();
    set_flags(4'b0100);
    drive(1'b1, 32'd0, 4'b0000, 32'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (branch_taken_o !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_eq_taken: got %b want 1", branch_taken_o);
    end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (branch_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_flushed: got %b want 0", branch_taken_o);
    end
    flush_i = 1'b0;
    cond_i  = 4'b0001;
    #1;
    n_checks++;
    if (branch_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_ne_not_taken: got %b want 0", branch_taken_o);
    end
    cond_i  = 4'b0000;
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (branch_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_invalid: got %b want 0", branch_taken_o);
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'd42, 4'b1001, 32'd7, 4'd4, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd43, 4'b0011, 32'd8, 4'd12, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    stall_i = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, reg_write_o, result_o, rd_o, flags_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got valid=%b result=%0d rd=%0d flags=%b want all zero", valid_o, result_o, rd_o, flags_o);
    end
    drive_idle();
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (valid_o !== 1'b0 || result_o !== 32'd0 || flags_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_stall_lost: got valid=%b result=%0d flags=%b want 0 0 0000", valid_o, result_o, flags_o);
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_cond_eq_ne();
    test_signed_compare();
    test_stall();
    test_flush_stall();
    test_branch();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
